mtm_alu_sequencer: RTL and testbench

- Sits between the serial-frame deserializer and the 32-bit ALU datapath, and between the ALU and the output serializer.
- Queues decoded frames (A, B, CTL) and launches ALU operations one at a time.
- Waits for ALU completion, with a timeout, and hands each result or error frame to the serializer over a valid/ready handshake.
- Error frames from the deserializer bypass the ALU.

---
 rtl/mtm_alu_sequencer_if.sv | 38 +++
 rtl/mtm_alu_sequencer.sv | 124 ++++++++++++
 tb/tb_mtm_alu_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mtm_alu_sequencer_if.sv
// Frame, ALU and serializer signals of the ALU sequencer.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface mtm_alu_sequencer_if;
  logic        des_valid;
  logic [31:0] des_A;
  logic [31:0] des_B;
  logic [7:0]  des_CTL;

  logic        alu_start;
  logic [31:0] alu_A;
  logic [31:0] alu_B;
  logic [2:0]  alu_op;
  logic        alu_done;
  logic [31:0] alu_C;
  logic [3:0]  alu_flags;

  logic        ser_valid;
  logic        ser_ready;
  logic        ser_err;
  logic [31:0] ser_C;
  logic [7:0]  ser_CTL;

  modport slave (
    input  des_valid, des_A, des_B, des_CTL,
    output alu_start, alu_A, alu_B, alu_op,
    input  alu_done, alu_C, alu_flags,
    output ser_valid, ser_err, ser_C, ser_CTL,
    input  ser_ready
  );

  modport master (
    output des_valid, des_A, des_B, des_CTL,
    input  alu_start, alu_A, alu_B, alu_op,
    output alu_done, alu_C, alu_flags,
    input  ser_valid, ser_err, ser_C, ser_CTL,
    output ser_ready
  );
endinterface

// File: rtl/mtm_alu_sequencer.sv
// Queues deserialized frames, runs them one at a time through the ALU with a
// completion timeout, and hands result/error frames to the serializer.
module mtm_alu_sequencer #(
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mtm_alu_sequencer_if.slave bus,
  output logic               overflow,
  output logic               busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] ERR_CODE = 8'h93;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  ctl;
  } frame_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

  frame_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, push, pop;
  frame_t        head;

  state_t        state, state_d;
  logic [CW-1:0] cnt;
  logic          op_ok, is_err_code, timed_out;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr];
  // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
  assign push  = bus.des_valid && (!full || pop);

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.des_A, bus.des_B, bus.des_CTL};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      if (bus.des_valid && !push) overflow <= 1'b1;
    end

  assign is_err_code = head.ctl inside {8'hC9, 8'hA5, 8'h93};
  assign op_ok       = !head.ctl[7] && (head.ctl[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101});
  // cnt holds cycles elapsed since alu_start, so the last WAIT cycle is TIMEOUT-1.
  assign timed_out   = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    case (state)
      IDLE:    if (!empty) begin
                 pop     = 1'b1;
                 state_d = op_ok ? ISSUE : OUTPUT;
               end
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.alu_done || timed_out) state_d = OUTPUT;
      OUTPUT:  if (bus.ser_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.alu_A   <= '0;
      bus.alu_B   <= '0;
      bus.alu_op  <= '0;
      bus.ser_err <= 1'b0;
      bus.ser_C   <= '0;
      bus.ser_CTL <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (!empty) begin
          if (op_ok) begin
            bus.alu_A  <= head.a;
            bus.alu_B  <= head.b;
            bus.alu_op <= head.ctl[6:4];
          end else begin
            bus.ser_err <= 1'b1;
            bus.ser_C   <= '0;
            bus.ser_CTL <= is_err_code ? head.ctl : ERR_CODE;
          end
        end
        ISSUE: cnt <= CW'(1);
        WAIT: begin
          // done takes priority over an expiring timeout
          if (bus.alu_done) begin
            bus.ser_err <= 1'b0;
            bus.ser_C   <= bus.alu_C;
            bus.ser_CTL <= {1'b0, bus.alu_flags, 3'b000};
          end else if (timed_out) begin
            bus.ser_err <= 1'b1;
            bus.ser_C   <= '0;
            bus.ser_CTL <= ERR_CODE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end

  assign bus.alu_start = (state == ISSUE);
  assign bus.ser_valid = (state == OUTPUT);
  assign busy          = !empty || (state != IDLE);
endmodule

// File: tb/tb_mtm_alu_sequencer.sv
// Scoreboard bench: stimulus queues expected frames, an ALU responder answers
// launches, and a negedge monitor compares every accepted output frame.
module tb_mtm_alu_sequencer;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic overflow, busy;

  mtm_alu_sequencer_if bus();

  mtm_alu_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .overflow(overflow), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  typedef struct { logic err; logic [31:0] c; logic [7:0] ctl; } exp_t;
  typedef struct { logic [31:0] a; logic [31:0] b; logic [2:0] op; int dly; } job_t;

  exp_t exp_q[$];
  job_t job_q[$];
  int checks = 0, errors = 0;
  int cyc = 0;
  int start_cnt = 0, start_cyc = 0, rise_cnt = 0, rise_cyc = 0, push_cyc = 0;
  int rdy_mode = 0;
  logic rdy_manual = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural ALU: returns {C, carry, overflow, zero, negative}.
  function automatic logic [35:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    logic [32:0] r;
    logic v;
    v = 1'b0;
    case (op)
      3'b000: begin r = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: r = {1'b0, a & b};
      3'b100: r = {1'b0, a | b};
      default: begin r = {1'b0, a} - {1'b0, b}; v = (a[31] != b[31]) && (r[31] != a[31]); end
    endcase
    return {r[31:0], r[32], v, r[31:0] == 32'd0, r[31]};
  endfunction

  // dly: cycles from launch to done; 0 means the ALU never answers.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [7:0] ctl,
                      input int dly, input bit dropped);
    exp_t e;
    job_t j;
    logic [35:0] r;
    if (!dropped) begin
      if (ctl inside {8'hC9, 8'hA5, 8'h93}) e = '{1'b1, 32'd0, ctl};
      else if (!ctl[7] && (ctl[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101})) begin
        j = '{a, b, ctl[6:4], dly};
        job_q.push_back(j);
        if (dly >= 1 && dly < TIMEOUT) begin
          r = alu_ref(a, b, ctl[6:4]);
          e = '{1'b0, r[35:4], {1'b0, r[3:0], 3'b000}};
        end else e = '{1'b1, 32'd0, 8'h93};
      end else e = '{1'b1, 32'd0, 8'h93};
      exp_q.push_back(e);
    end
    push_cyc      = cyc;
    bus.des_valid = 1'b1;
    bus.des_A     = a;
    bus.des_B     = b;
    bus.des_CTL   = ctl;
    @(posedge clk); #1;
    bus.des_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_count(input string name, input int which, input int base, input int bound);
    int n;
    n = 0;
    while (((which == 0) ? start_cnt : rise_cnt) == base && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n < bound, 1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    bus.ser_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.ser_ready = (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : rdy_manual;
    end
  end

  // ALU responder
  initial begin
    job_t j;
    logic [35:0] r;
    bus.alu_done = 1'b0; bus.alu_C = '0; bus.alu_flags = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.alu_start) begin
        if (job_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL alu_start: launch with no queued job");
        end else begin
          j = job_q.pop_front();
          check("alu_operands", {bus.alu_A, bus.alu_B, bus.alu_op}, {j.a, j.b, j.op});
          if (j.dly > 0) begin
            r = alu_ref(j.a, j.b, j.op);
            repeat (j.dly) @(posedge clk);
            #1; bus.alu_done = 1'b1; bus.alu_C = r[35:4]; bus.alu_flags = r[3:0];
            @(posedge clk);
            #1; bus.alu_done = 1'b0; bus.alu_C = $urandom; bus.alu_flags = 4'($urandom);
          end
        end
      end
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic pv, pr, ps;
    logic [40:0] pf;
    exp_t e;
    pv = 1'b0; pr = 1'b0; ps = 1'b0; pf = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0; ps = 1'b0;
      end else begin
        if (bus.alu_start) begin
          check("start_width", ps, 0);
          start_cnt++;
          start_cyc = cyc;
        end
        if (bus.ser_valid && !pv) begin
          rise_cnt++;
          rise_cyc = cyc;
        end
        if (pv && !pr)
          check("hold", {bus.ser_valid, bus.ser_err, bus.ser_C, bus.ser_CTL}, {1'b1, pf});
        if (bus.ser_valid && bus.ser_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL frame: unexpected err=%0d C=%0h CTL=%0h", bus.ser_err, bus.ser_C, bus.ser_CTL);
          end else begin
            e = exp_q.pop_front();
            check("frame", {bus.ser_err, bus.ser_C, bus.ser_CTL}, {e.err, e.c, e.ctl});
          end
        end
        pv = bus.ser_valid; pr = bus.ser_ready; ps = bus.alu_start;
        pf = {bus.ser_err, bus.ser_C, bus.ser_CTL};
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, n;
    logic [2:0] op;
    logic [7:0] ctl;
    int dly;
    rst_n = 1'b0;
    bus.des_valid = 1'b0; bus.des_A = '0; bus.des_B = '0; bus.des_CTL = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_outputs", {bus.alu_start, bus.alu_op, bus.ser_valid, bus.ser_err, bus.ser_CTL,
                          overflow, busy, bus.ser_C, bus.alu_A, bus.alu_B}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic add, immediate ALU
    rdy_manual = 1'b1;
    s0 = start_cnt;
    send(32'd5, 32'd3, 8'h00, 1, 0);
    check("busy_after_push", busy, 1);
    wait_drain(40);
    check("lat_data", rise_cyc - push_cyc, 4);
    check("start_once", start_cnt - s0, 1);
    check("busy_idle", busy, 0);

    // error bypass
    s0 = start_cnt;
    send($urandom, $urandom, 8'hA5, 0, 0);
    wait_drain(40);
    check("lat_err", rise_cyc - push_cyc, 2);
    check("no_start_err", start_cnt - s0, 0);

    // illegal opcode
    send($urandom, $urandom, 8'h30, 1, 0);
    wait_drain(40);

    // ALU timeout, then done on the last permitted cycle
    send($urandom, $urandom, 8'h40, 0, 0);
    wait_drain(80);
    check("timeout_lat", rise_cyc - start_cyc, TIMEOUT);
    send($urandom, $urandom, 8'h50, TIMEOUT - 1, 0);
    wait_drain(80);
    check("done_limit_lat", rise_cyc - start_cyc, TIMEOUT);

    // overflow with output stalled
    rdy_manual = 1'b0;
    r0 = rise_cnt;
    send($urandom, $urandom, 8'h10, 1, 0);
    wait_count("stall_rise", 1, r0, 20);
    check("no_overflow_yet", overflow, 0);
    send($urandom, $urandom, 8'hC9, 0, 0);
    send($urandom, $urandom, 8'h00, 2, 0);
    send($urandom, $urandom, 8'h40, 1, 1);
    check("overflow_set", overflow, 1);
    repeat (5) @(posedge clk); #1;
    rdy_mode = 1;
    wait_drain(300);
    rdy_mode = 0;
    check("overflow_sticky", overflow, 1);

    // reset during WAIT, done lands right after release
    rdy_manual = 1'b1;
    s0 = start_cnt;
    send($urandom, $urandom, 8'h00, 4, 0);
    wait_count("reset_start", 0, s0, 20);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    job_q.delete();
    @(posedge clk); #1;
    check("rst_mid", {bus.alu_start, bus.alu_op, bus.ser_valid, bus.ser_err, bus.ser_CTL,
                      overflow, busy, bus.ser_C, bus.alu_A, bus.alu_B}, 0);
    rst_n = 1'b1;
    r0 = rise_cnt;
    repeat (8) @(posedge clk); #1;
    check("rst_no_output", rise_cnt - r0, 0);
    check("rst_idle", {bus.ser_valid, bus.alu_start, overflow, busy}, 0);

    // push and pop on a full FIFO in the same cycle
    rdy_manual = 1'b0;
    send($urandom, $urandom, 8'hC9, 0, 0);
    send($urandom, $urandom, 8'h00, 1, 0);
    send($urandom, $urandom, 8'h51, 2, 0);
    repeat (3) @(posedge clk); #1;
    check("full_busy", busy, 1);
    rdy_manual = 1'b1;
    @(posedge clk); #1;
    rdy_manual = 1'b0;
    send($urandom, $urandom, 8'hA5, 0, 0);
    check("full_pushpop_no_ovf", overflow, 0);
    rdy_mode = 1;
    wait_drain(300);

    // randomized bursts
    for (int b = 0; b < 40; b++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 5))
          0, 1, 2: begin
            op  = 3'($urandom_range(0, 3));
            ctl = {1'b0, op[1], 1'b0, op[0], 4'($urandom)};
          end
          3: case ($urandom_range(0, 2))
               0: ctl = 8'hC9;
               1: ctl = 8'hA5;
               default: ctl = 8'h93;
             endcase
          4: begin
            op  = 3'($urandom);
            ctl = {1'b0, op[1], 1'b1, op[0], 4'($urandom)};
          end
          default: ctl = {1'b1, 7'($urandom)};
        endcase
        case ($urandom_range(0, 9))
          0: dly = 0;
          1: dly = TIMEOUT;
          2: dly = TIMEOUT - 1;
          default: dly = $urandom_range(1, 4);
        endcase
        send($urandom, $urandom, ctl, dly, 0);
      end
      wait_drain(400);
    end
    rdy_mode = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
